// File: rtl/block_clear_writer.sv
// Block state writer: fills the block field, clears hit blocks by read-modify-write of row words,
// counts remaining blocks. Define BLOCK_CLEAR_SCORE_EN to add the saturating score output.
module block_clear_writer #(
  parameter int unsigned NUM_COLS = 13,
  parameter int unsigned NUM_ROWS = 8,
  parameter int unsigned ROW_BITS = 3,
  parameter int unsigned BLOCK_X0 = 60,
  parameter int unsigned BLOCK_Y0 = 48,
  parameter int unsigned BLOCK_W  = 40,
  parameter int unsigned BLOCK_H  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_pulse,
  input  logic                hit,
  input  logic [9:0]          hit_x,
  input  logic [8:0]          hit_y,
  input  logic                restart,
  output logic [ROW_BITS-1:0] mem_addr,
  input  logic [NUM_COLS-1:0] mem_rd_data,
  output logic [NUM_COLS-1:0] mem_wr_data,
  output logic                mem_we,
  output logic                busy,
  output logic                block_destroyed,
  output logic [7:0]          blocks_left,
  output logic                level_clear
`ifdef BLOCK_CLEAR_SCORE_EN
  ,
  output logic [11:0]         score
`endif
);

  localparam int unsigned ColBits = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  localparam logic [9:0]          XLo      = 10'(BLOCK_X0);
  localparam logic [9:0]          XHi      = 10'(BLOCK_X0 + NUM_COLS * BLOCK_W);
  localparam logic [8:0]          YLo      = 9'(BLOCK_Y0);
  localparam logic [8:0]          YHi      = 9'(BLOCK_Y0 + NUM_ROWS * BLOCK_H);
  localparam logic [9:0]          XStep    = 10'(BLOCK_W);
  localparam logic [8:0]          YStep    = 9'(BLOCK_H);
  localparam logic [7:0]          TotalBlk = 8'(NUM_ROWS * NUM_COLS);
  localparam logic [ROW_BITS:0]   InitEnd  = (ROW_BITS + 1)'(NUM_ROWS);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StCalc,
    StRead,
    StModify,
    StWrite
  } state_e;

  state_e                state_q, state_d;
  logic [ROW_BITS:0]     init_cnt_q, init_cnt_d;
  logic                  armed_q, armed_d;
  logic [9:0]            x_rem_q, x_rem_d;
  logic [8:0]            y_rem_q, y_rem_d;
  logic [ColBits-1:0]    col_q, col_d;
  logic [ROW_BITS-1:0]   row_q, row_d;

  // Next values of the registered outputs
  logic [ROW_BITS-1:0]   addr_d;
  logic [NUM_COLS-1:0]   wr_data_d;
  logic                  we_d;
  logic                  destroyed_d;
  logic [7:0]            blocks_left_d;
  logic                  level_clear_d;

  logic                  in_field;
  logic [NUM_COLS-1:0]   col_mask;

`ifdef BLOCK_CLEAR_SCORE_EN
  logic [11:0]           score_d;
  logic [11:0]           row_worth;
  logic [12:0]           score_sum;

  assign row_worth = 12'(NUM_ROWS) - 12'(row_q);
  assign score_sum = {1'b0, score} + {1'b0, row_worth};
`endif

  assign in_field = (hit_x >= XLo) && (hit_x < XHi) && (hit_y >= YLo) && (hit_y < YHi);
  assign col_mask = {{(NUM_COLS - 1){1'b0}}, 1'b1} << col_q;

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    armed_d       = armed_q;
    x_rem_d       = x_rem_q;
    y_rem_d       = y_rem_q;
    col_d         = col_q;
    row_d         = row_q;
    addr_d        = '0;
    wr_data_d     = '0;
    we_d          = 1'b0;
    destroyed_d   = 1'b0;
    blocks_left_d = blocks_left;
    level_clear_d = level_clear | (blocks_left == 8'd0);
`ifdef BLOCK_CLEAR_SCORE_EN
    score_d       = score;
`endif

    unique case (state_q)
      StInit: begin
        // init_cnt_q is the next row to fill; the write shows up one cycle later
        if (init_cnt_q < InitEnd) begin
          we_d       = 1'b1;
          addr_d     = init_cnt_q[ROW_BITS-1:0];
          wr_data_d  = '1;
          init_cnt_d = init_cnt_q + (ROW_BITS + 1)'(1);
        end else begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (hit && armed_q && in_field) begin
          x_rem_d = hit_x - XLo;
          y_rem_d = hit_y - YLo;
          col_d   = '0;
          row_d   = '0;
          armed_d = 1'b0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (x_rem_q >= XStep) begin
          x_rem_d = x_rem_q - XStep;
          col_d   = col_q + ColBits'(1);
        end else if (y_rem_q >= YStep) begin
          y_rem_d = y_rem_q - YStep;
          row_d   = row_q + ROW_BITS'(1);
        end else begin
          addr_d  = row_q;
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = StModify;
      end
      StModify: begin
        // A cleared bit means a stale hit on an already destroyed block
        if (mem_rd_data[col_q]) begin
          we_d        = 1'b1;
          addr_d      = row_q;
          wr_data_d   = mem_rd_data & ~col_mask;
          destroyed_d = 1'b1;
          if (blocks_left != 8'd0) begin
            blocks_left_d = blocks_left - 8'd1;
          end
`ifdef BLOCK_CLEAR_SCORE_EN
          score_d = score_sum[12] ? 12'hFFF : score_sum[11:0];
`endif
          state_d = StWrite;
        end else begin
          state_d = StIdle;
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (frame_pulse) begin
      armed_d = 1'b1;
    end

    if (restart) begin
      state_d       = StInit;
      init_cnt_d    = '0;
      armed_d       = 1'b1;
      blocks_left_d = TotalBlk;
      level_clear_d = 1'b0;
      we_d          = 1'b0;
      addr_d        = '0;
      wr_data_d     = '0;
      destroyed_d   = 1'b0;
`ifdef BLOCK_CLEAR_SCORE_EN
      score_d       = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StInit;
      init_cnt_q      <= '0;
      armed_q         <= 1'b1;
      x_rem_q         <= '0;
      y_rem_q         <= '0;
      col_q           <= '0;
      row_q           <= '0;
      mem_addr        <= '0;
      mem_wr_data     <= '0;
      mem_we          <= 1'b0;
      busy            <= 1'b1;
      block_destroyed <= 1'b0;
      blocks_left     <= TotalBlk;
      level_clear     <= 1'b0;
`ifdef BLOCK_CLEAR_SCORE_EN
      score           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      init_cnt_q      <= init_cnt_d;
      armed_q         <= armed_d;
      x_rem_q         <= x_rem_d;
      y_rem_q         <= y_rem_d;
      col_q           <= col_d;
      row_q           <= row_d;
      mem_addr        <= addr_d;
      mem_wr_data     <= wr_data_d;
      mem_we          <= we_d;
      busy            <= (state_d != StIdle);
      block_destroyed <= destroyed_d;
      blocks_left     <= blocks_left_d;
      level_clear     <= level_clear_d;
`ifdef BLOCK_CLEAR_SCORE_EN
      score           <= score_d;
`endif
    end
  end

endmodule

// File: tb/tb_block_clear_writer.sv
// Directed bench for block_clear_writer with a synchronous-read row RAM model.
module tb_block_clear_writer;

  logic        clk;
  logic        rst;
  logic        frame_pulse;
  logic        hit;
  logic [9:0]  hit_x;
  logic [8:0]  hit_y;
  logic        restart;
  logic [2:0]  mem_addr;
  logic [12:0] mem_rd_data;
  logic [12:0] mem_wr_data;
  logic        mem_we;
  logic        busy;
  logic        block_destroyed;
  logic [7:0]  blocks_left;
  logic        level_clear;
`ifdef BLOCK_CLEAR_SCORE_EN
  logic [11:0] score;
`endif

  block_clear_writer dut (
    .clk             (clk),
    .rst             (rst),
    .frame_pulse     (frame_pulse),
    .hit             (hit),
    .hit_x           (hit_x),
    .hit_y           (hit_y),
    .restart         (restart),
    .mem_addr        (mem_addr),
    .mem_rd_data     (mem_rd_data),
    .mem_wr_data     (mem_wr_data),
    .mem_we          (mem_we),
    .busy            (busy),
    .block_destroyed (block_destroyed),
    .blocks_left     (blocks_left),
    .level_clear     (level_clear)
`ifdef BLOCK_CLEAR_SCORE_EN
    ,
    .score           (score)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] ram [8];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wr_data;
    mem_rd_data <= ram[mem_addr];
  end

  int n_vec  = 0;
  int n_miss = 0;

  // Results captured by do_hit
  int          w_cnt, d_cnt, w_lat;
  bit          busy_seen;
  logic [2:0]  w_addr, rd_addr;
  logic [12:0] w_data;
  logic [7:0]  w_left;
  logic        w_destr, w_lvl;

  logic [12:0] exp_field [8];
  int          exp_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_frame();
    frame_pulse = 1'b1;
    @(negedge clk);
    frame_pulse = 1'b0;
  endtask

  // Called at a negedge; applies a one-cycle hit and watches a fixed window of cycles
  task automatic do_hit(input logic [9:0] x, input logic [8:0] y, input int cycles);
    logic [2:0] h1, h2;
    h1 = '0; h2 = '0;
    w_cnt = 0; d_cnt = 0; w_lat = -1; busy_seen = 1'b0;
    w_addr = '0; rd_addr = '0; w_data = '0; w_left = '0; w_destr = 1'b0; w_lvl = 1'b0;
    hit_x = x; hit_y = y; hit = 1'b1;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      hit = 1'b0;
      if (busy) busy_seen = 1'b1;
      if (block_destroyed) d_cnt++;
      if (mem_we) begin
        if (w_cnt == 0) begin
          w_lat   = k - 1;
          w_addr  = mem_addr;
          w_data  = mem_wr_data;
          w_left  = blocks_left;
          w_destr = block_destroyed;
          w_lvl   = level_clear;
          rd_addr = h2;
        end
        w_cnt++;
      end
      h2 = h1;
      h1 = mem_addr;
    end
  endtask

  task automatic init_sweep(input string tag);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      check($sformatf("%s_we%0d", tag, r), mem_we, 1);
      check($sformatf("%s_addr%0d", tag, r), mem_addr, r);
      check($sformatf("%s_data%0d", tag, r), mem_wr_data, 13'h1FFF);
    end
    @(negedge clk);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_we_done"}, mem_we, 0);
    check({tag, "_left"}, blocks_left, 104);
    check({tag, "_lvl"}, level_clear, 0);
  endtask

  initial begin
    int quiet_we;
    rst = 1'b1; frame_pulse = 1'b0; hit = 1'b0; hit_x = '0; hit_y = '0; restart = 1'b0;
    for (int r = 0; r < 8; r++) exp_field[r] = 13'h1FFF;
    exp_left = 104;

    @(negedge clk);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_wr_data, 0);
    check("rst_busy", busy, 1);
    check("rst_left", blocks_left, 104);
    check("rst_lvl", level_clear, 0);
    check("rst_destr", block_destroyed, 0);
    rst = 1'b0;
    init_sweep("init");

    // col 2 row 1
    pulse_frame();
    do_hit(10'd145, 9'd70, 25);
    check("h1_wcnt", w_cnt, 1);
    check("h1_lat", w_lat, 6);
    check("h1_rdaddr", rd_addr, 1);
    check("h1_addr", w_addr, 1);
    check("h1_data", w_data, 13'h1FFB);
    check("h1_destr", w_destr, 1);
    check("h1_dcnt", d_cnt, 1);
    check("h1_left", w_left, 103);
    check("h1_busy_end", busy, 0);
    exp_field[1] = 13'h1FFB;

    // Two hits in one frame: second dropped
    pulse_frame();
    do_hit(10'd60, 9'd48, 25);
    check("h2a_wcnt", w_cnt, 1);
    check("h2a_lat", w_lat, 3);
    check("h2a_data", w_data, 13'h1FFE);
    check("h2a_left", w_left, 102);
    exp_field[0] = 13'h1FFE;
    do_hit(10'd100, 9'd48, 25);
    check("h2b_wcnt", w_cnt, 0);
    check("h2b_busy", busy_seen, 0);
    pulse_frame();
    do_hit(10'd579, 9'd175, 25);
    check("h3_wcnt", w_cnt, 1);
    check("h3_lat", w_lat, 22);
    check("h3_addr", w_addr, 7);
    check("h3_data", w_data, 13'h0FFF);
    check("h3_left", w_left, 101);
    exp_field[7] = 13'h0FFF;
    exp_left = 101;

    // Stale hit on a cleared block
    pulse_frame();
    do_hit(10'd145, 9'd70, 25);
    check("stale_wcnt", w_cnt, 0);
    check("stale_dcnt", d_cnt, 0);
    check("stale_busy", busy_seen, 1);
    check("stale_left", blocks_left, 101);

    // Out-of-field hits
    pulse_frame();
    do_hit(10'd59, 9'd70, 8);
    check("oof_x59_busy", busy_seen, 0);
    check("oof_x59_wcnt", w_cnt, 0);
    do_hit(10'd300, 9'd176, 8);
    check("oof_y176_busy", busy_seen, 0);
    do_hit(10'd580, 9'd48, 8);
    check("oof_x580_busy", busy_seen, 0);

    // Clear every remaining block
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 13; c++) begin
        if (exp_field[r][c]) begin
          pulse_frame();
          do_hit(10'(60 + 40 * c), 9'(48 + 16 * r), 25);
          exp_field[r][c] = 1'b0;
          exp_left--;
          check($sformatf("clr_r%0dc%0d_wcnt", r, c), w_cnt, 1);
          check($sformatf("clr_r%0dc%0d_addr", r, c), w_addr, r);
          check($sformatf("clr_r%0dc%0d_data", r, c), w_data, exp_field[r]);
          check($sformatf("clr_r%0dc%0d_left", r, c), w_left, exp_left);
          check($sformatf("clr_r%0dc%0d_lat", r, c), w_lat, c + r + 3);
        end
      end
    end
    check("last_left", w_left, 0);
    check("last_lvl_at_write", w_lvl, 0);
    check("lvl_after", level_clear, 1);
    check("left_after", blocks_left, 0);

    pulse_frame();
    do_hit(10'd60, 9'd48, 25);
    check("empty_wcnt", w_cnt, 0);
    check("empty_left", blocks_left, 0);
    check("empty_lvl", level_clear, 1);

    // Restart refills the field
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_we0", mem_we, 0);
    check("rs_busy", busy, 1);
    check("rs_left0", blocks_left, 104);
    check("rs_lvl0", level_clear, 0);
    init_sweep("rs");

    // Restart during CALC aborts the hit
    pulse_frame();
    hit_x = 10'd579; hit_y = 9'd175; hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    check("rc_busy_calc", busy, 1);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rc_we0", mem_we, 0);
    check("rc_busy", busy, 1);
    init_sweep("rc");
    quiet_we = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (mem_we || block_destroyed) quiet_we++;
    end
    check("rc_no_write", quiet_we, 0);
    check("rc_left", blocks_left, 104);

`ifdef BLOCK_CLEAR_SCORE_EN
    check("score_start", score, 0);
    pulse_frame();
    do_hit(10'd145, 9'd70, 25);
    check("score_row1", score, 7);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("score_restart", score, 0);
    init_sweep("sc");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/block_clear_writer.md
Name: block_clear_writer

Overview:
- Write-side counterpart of the block state storage, which the blocks painter reads one line at a time.
- Takes a ball/block collision pixel, decodes it to a block row and column, then read-modify-writes that row word to clear the hit block's bit.
- Also fills the field on reset or level restart, counts remaining blocks and flags level clear.
- Sits between the collision logic and the block state RAM write port.

Parameters:
NUM_COLS, 13, blocks per row (row word width)
NUM_ROWS, 8, block rows
ROW_BITS, 3, row address width (>= clog2(NUM_ROWS))
BLOCK_X0, 60, left pixel of block field
BLOCK_Y0, 48, top line of block field
BLOCK_W, 40, block width in pixels
BLOCK_H, 16, block height in lines

Ports:
clk  in  1  system/pixel clock
rst  in  1  synchronous reset, active-high
frame_pulse  in  1  one-cycle start-of-frame strobe
hit  in  1  one-cycle strobe: ball pixel overlaps block pixel
hit_x  in  10  hpos at hit
hit_y  in  9  vpos at hit
restart  in  1  refill field, restart level
mem_addr  out  ROW_BITS  row address to block state RAM
mem_rd_data  in  NUM_COLS  row word, valid 1 cycle after mem_addr (synchronous read)
mem_wr_data  out  NUM_COLS  row word to write
mem_we  out  1  write strobe
busy  out  1  state != IDLE
block_destroyed  out  1  one-cycle pulse per cleared block
blocks_left  out  8  remaining blocks
level_clear  out  1  high while blocks_left == 0 after a clear

Behaviour:
- Bit c of a row word = column c; column 0 is leftmost. 1 = block present.
- States: INIT, IDLE, CALC, READ, MODIFY, WRITE.
- Reset (rst high at a clock edge):
  - state=INIT, init row=0, armed=1, blocks_left=NUM_ROWS*NUM_COLS (104), level_clear=0, block_destroyed=0.
  - mem_we=0, mem_addr=0, mem_wr_data=0 while rst is high.
- INIT: one row per cycle.
  - mem_we=1, mem_addr=row, mem_wr_data=all ones, for rows 0..NUM_ROWS-1 on consecutive cycles, then IDLE.
  - hit is ignored throughout INIT.
- restart:
  - In any state, restart forces INIT next cycle and aborts any in-flight operation with no write.
  - Resets blocks_left, clears level_clear, sets armed=1.
  - While restart stays high, INIT holds at row 0.
- IDLE: mem_we=0, mem_addr=0, mem_wr_data=0.
  - Accepts hit only if armed=1 and BLOCK_X0 <= hit_x < BLOCK_X0+NUM_COLS*BLOCK_W and BLOCK_Y0 <= hit_y < BLOCK_Y0+NUM_ROWS*BLOCK_H.
  - On accept: latch x_rem=hit_x-BLOCK_X0 and y_rem=hit_y-BLOCK_Y0; col=0, row=0; armed=0; go to CALC.
  - Out-of-field hits, and hits while busy, are dropped silently.
- armed: set by frame_pulse. If frame_pulse and an accepted hit occur in the same cycle, the hit is accepted and armed ends at 1. Result: at most one clear per frame, plus the coincident case.
- CALC: one subtraction per cycle, no divider.
  - If x_rem >= BLOCK_W: x_rem -= BLOCK_W, col++.
  - Else if y_rem >= BLOCK_H: y_rem -= BLOCK_H, row++.
  - Else go to READ.
- READ: drive mem_addr=row; go to MODIFY.
- MODIFY: mem_rd_data is valid here.
  - If bit[col]=1: go to WRITE.
  - If bit[col]=0 (stale pixel, already cleared): go to IDLE with no write and no decrement.
- WRITE: single cycle.
  - mem_we=1, mem_addr=row, mem_wr_data=rd_data with bit col cleared.
  - block_destroyed=1 and blocks_left decrements, both in this cycle.
  - Then IDLE.
- Latency from accepted hit to write strobe: col+row+3 cycles; maximum NUM_COLS+NUM_ROWS+1.
- level_clear: set the cycle after blocks_left reaches 0; held until rst or restart. blocks_left never underflows.
- All outputs are registered.

Optional Feature:
- Macro: BLOCK_CLEAR_SCORE_EN.
- Defined:
  - Adds output port score (12 bits).
  - Reset and restart set score=0.
  - Each WRITE adds NUM_ROWS-row (top row worth most); saturates at 4095.
- Undefined: no score port and no score logic; all other behaviour identical.

Test Plan:
- rst for 1 cycle -> 8 consecutive mem_we cycles, addr 0..7, data 0x1FFF; then busy=0, blocks_left=104, level_clear=0.
- After init, frame_pulse, then hit at (145,70) -> col 2, row 1; mem_addr=1 read; RAM returns 0x1FFF -> one write addr 1 data 0x1FFB, 6 cycles after hit; block_destroyed pulse; blocks_left=103.
- Two in-field hits within one frame -> only the first is processed; after the next frame_pulse, a hit at (579,175) clears col 12 row 7 (addr 7, data 0x0FFF).
- Hit decoding to a bit already 0 -> no mem_we, no block_destroyed, blocks_left unchanged. Hits at (59,70) and (300,176) -> ignored, busy stays 0.
- Preload blocks_left=1 via 103 successive clears, then a final hit -> blocks_left=0 and level_clear=1. Then restart -> INIT sweep, blocks_left=104, level_clear=0.
- restart asserted during CALC -> no write for the aborted hit, INIT starts next cycle. With BLOCK_CLEAR_SCORE_EN: hit on row 1 -> score=7; restart -> score=0.
